multi_ch_accum: RTL and testbench
=================================

MULTI_CH_ACCUM -- requirements
Module: multi_ch_accum

Interface
REQ-001 Parameter BITS, default 32: unsigned sample width per channel.
REQ-002 Parameter CGES, default 50: samples per accumulation window (legal range 2..65535).
REQ-003 Parameter CH, default 4: number of independent channels.
REQ-004 Derived constant ACCW = $clog2(CGES)+BITS: per-channel result width.
REQ-005 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  level/pulse; begins a window when sampled high in IDLE.
REQ-008 fin  input  1  abort; returns the block to IDLE.
REQ-009 mode  input  1  0 = one-shot, 1 = continuous; sampled only on an accepted start.
REQ-010 in_valid  input  1  sample-vector valid.
REQ-011 in_data  input  CH*BITS  channel k occupies bits [k*BITS +: BITS].
REQ-012 in_ready  output  1  block accepts in_data this cycle.
REQ-013 out_valid  output  1  result vector valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 result  output  CH*ACCW  channel k sum at [k*ACCW +: ACCW].
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 count  output  $clog2(CGES)  samples accepted in the current window.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACC and HOLD.
REQ-019 IDLE: start=1 and fin=0 -> ACC, with all accumulators and count cleared on that edge and mode latched.
REQ-020 Accept = in_valid & in_ready; on an accept, each lane SHALL add zero-extended in_data[k] to its accumulator, and count SHALL increment.
REQ-021 in_ready SHALL be high only in ACC, and low whenever out_valid=1 and out_ready=0.
REQ-022 On the accept that brings count to CGES (count = CGES-1 beforehand), accumulator+sample SHALL be registered into result, out_valid SHALL be set, and count and accumulators SHALL clear; result is visible one cycle after the last sample.
REQ-023 At that event, one-shot mode -> HOLD; continuous mode stays in ACC and immediately starts the next window.
REQ-024 out_valid SHALL stay high with result stable until out_valid & out_ready, and SHALL clear on that edge unless a new result loads on the same edge (in which case it stays set with the new value).
REQ-025 HOLD: out_valid & out_ready -> IDLE.
REQ-026 fin=1 from any state -> IDLE on the next edge, clearing accumulators, count and out_valid; fin has priority over start, accepts and completion events on the same cycle.
REQ-027 start while in ACC or HOLD SHALL be ignored.
REQ-028 Arithmetic SHALL be unsigned; ACCW SHALL be sufficient so that no overflow or saturation logic exists.
REQ-029 Channels SHALL share count and the handshake; only data paths are per-channel.

Reset
REQ-030 When reset_n=0, asynchronously: state=IDLE, accumulators=0, result=0, count=0, out_valid=0, busy=0, in_ready=0.
REQ-031 Reset deassertion SHALL take effect at the first clk edge with reset_n=1, with no partial-window state surviving a mid-operation reset.

Structure
REQ-032 Package multi_ch_accum_pkg SHALL hold the state enum (IDLE, ACC, HOLD) and an ACCW helper function of BITS and CGES.
REQ-033 A sub-module accum_lane (one BITS-in/ACCW-out accumulator with clear, add-enable and load-result controls) SHALL be instantiated CH times via generate.

Verification
REQ-034 CH=4, CGES=50, one-shot, in_data lanes = 1,2,3,4 every cycle, out_ready=1 -> result lanes 50,100,150,200 one cycle after the 50th accept, then IDLE.
REQ-035 All lanes 32'hFFFF_FFFF for 50 samples -> each lane 38'h31_FFFF_FFCE (50*(2^32-1)), with no wrap.
REQ-036 Continuous mode, out_ready held 0 after the first result -> in_ready drops, result is held; out_ready=1 for one cycle -> transfer occurs, and the second window completes with the same sums.
REQ-037 fin asserted at count=25, same cycle as start=1 and in_valid=1 -> next cycle IDLE, count=0, out_valid=0, with no result produced.
REQ-038 in_valid toggled randomly over 50 accepts -> sum equals the sum of accepted samples only; count tracks accepts.
REQ-039 reset_n pulsed low mid-window (count=30) -> all outputs are 0 immediately, and a subsequent start yields the correct full-window sum.

Source files
------------

// File: rtl/multi_ch_accum_pkg.sv
// Shared types and helpers for the multi-channel window accumulator.
//   state_t : controller states (IDLE, ACC, HOLD)
//   accw_f  : per-channel result width for a given sample width and window length
package multi_ch_accum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // A window of cges samples of (2^bits - 1) each is strictly below
   // 2^($clog2(cges) + bits), so this width can never wrap.
   function automatic int accw_f(input int bits, input int cges);
      return $clog2(cges) + bits;
   endfunction

endpackage

// File: rtl/multi_ch_accum_lane.sv
// One accumulator lane: sums zero-extended samples and latches the window total.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the running sum (result register is kept)
//   add_en       : add sample to the running sum
//   load_res     : register running sum + sample into result, zero the running sum
//   sample       : BITS-wide unsigned input sample
//   result       : ACCW-wide registered window total
module accum_lane #(
   parameter int BITS = 32,
   parameter int ACCW = 38
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clear,
   input  logic            add_en,
   input  logic            load_res,
   input  logic [BITS-1:0] sample,
   output logic [ACCW-1:0] result
);

   logic [ACCW-1:0] acc;
   logic [ACCW-1:0] sum;

   assign sum = acc + ACCW'(sample);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         result <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (load_res) begin
         result <= sum;
         acc    <= '0;
      end else if (add_en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/multi_ch_accum.sv
// Multi-channel windowed accumulator. Each of CH lanes sums CGES accepted
// samples; the totals are presented together with a valid/ready handshake.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a window (honoured in IDLE only)
//   fin          : abort to IDLE, overrides everything else in the cycle
//   mode         : 0 one-shot, 1 continuous; captured when a window starts
//   in_valid/in_ready/in_data   : sample-vector input handshake, lane k at [k*BITS +: BITS]
//   out_valid/out_ready/result  : result-vector output handshake, lane k at [k*ACCW +: ACCW]
//   busy         : controller not in IDLE
//   count        : samples accepted so far in the current window
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; no window open
// ACC   | accepting samples; continuous mode stays here across windows
// HOLD  | one-shot window finished, waiting for the result to be taken
module multi_ch_accum
   import multi_ch_accum_pkg::*;
#(
   parameter  int BITS = 32,
   parameter  int CGES = 50,
   parameter  int CH   = 4,
   localparam int ACCW = accw_f(BITS, CGES),
   localparam int CW   = $clog2(CGES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               fin,
   input  logic               mode,
   input  logic               in_valid,
   input  logic [CH*BITS-1:0] in_data,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH*ACCW-1:0] result,
   output logic               busy,
   output logic [CW-1:0]      count
);

   state_t state, state_nxt;
   logic   mode_q;
   logic   start_acc;
   logic   accept;
   logic   last;
   logic   handshake;
   logic   lane_clr;

   assign start_acc = (state == IDLE) && start && !fin;
   // A result that has not been taken blocks input; fin also blocks input so
   // an upstream producer never sees a sample it offered during abort as taken.
   assign in_ready  = (state == ACC) && !fin && !(out_valid && !out_ready);
   assign accept    = in_valid && in_ready;
   assign last      = accept && (count == CW'(CGES - 1));
   assign handshake = out_valid && out_ready;
   assign lane_clr  = fin || start_acc;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_acc) state_nxt = ACC;
         ACC:     if (last && !mode_q) state_nxt = HOLD;
         HOLD:    if (handshake) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (fin) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nxt;

         if (start_acc) mode_q <= mode;

         if (fin || start_acc || last) count <= '0;
         else if (accept)              count <= count + CW'(1);

         // A new result landing on the same edge as a handshake keeps valid set.
         if (fin)            out_valid <= 1'b0;
         else if (last)      out_valid <= 1'b1;
         else if (handshake) out_valid <= 1'b0;
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_lane
      accum_lane #(
         .BITS (BITS),
         .ACCW (ACCW)
      ) u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .clear    (lane_clr),
         .add_en   (accept && !last),
         .load_res (last),
         .sample   (in_data[k*BITS +: BITS]),
         .result   (result[k*ACCW +: ACCW])
      );
   end

endmodule

// File: tb/tb_multi_ch_accum.sv
module tb_multi_ch_accum;

   localparam int BITS = 32;
   localparam int CGES = 50;
   localparam int CH   = 4;
   localparam int ACCW = 38;
   localparam int CW   = 6;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               start;
   logic               fin;
   logic               mode;
   logic               in_valid;
   logic [CH*BITS-1:0] in_data;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [CH*ACCW-1:0] result;
   logic               busy;
   logic [CW-1:0]      count;

   int n_chk  = 0;
   int n_fail = 0;

   multi_ch_accum #(.BITS(BITS), .CGES(CGES), .CH(CH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .fin       (fin),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [CH*ACCW-1:0] obs,
                        input logic [CH*ACCW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CH*ACCW-1:0] res4(input logic [ACCW-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [CH*BITS-1:0] dat4(input logic [BITS-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic open_window(input logic m);
      start = 1'b1;
      mode  = m;
      step();
      start = 1'b0;
   endtask

   logic [ACCW-1:0] sums [CH];
   logic [BITS-1:0] smp;
   int              acc_n;
   int              cyc;

   initial begin
      reset_n = 1'b0; start = 0; fin = 0; mode = 0;
      in_valid = 0; in_data = '0; out_ready = 1'b1;
      #12;
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_count", count, 0);
      check("rst_result", result, 0);
      #1 reset_n = 1'b1;
      step();

      // one-shot, lanes 1,2,3,4
      open_window(1'b0);
      check("os_busy", busy, 1);
      check("os_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = dat4(1, 2, 3, 4);
      feed(49);
      check("os_count49", count, 49);
      check("os_not_valid", out_valid, 0);
      feed(1);
      in_valid = 1'b0;
      check("os_valid", out_valid, 1);
      check("os_result", result, res4(50, 100, 150, 200));
      check("os_count0", count, 0);
      check("os_hold_busy", busy, 1);
      check("os_hold_rdy", in_ready, 0);
      step();
      check("os_idle_busy", busy, 0);
      check("os_idle_valid", out_valid, 0);

      // full-scale samples, no wrap
      open_window(1'b0);
      in_valid = 1'b1;
      in_data  = {CH{32'hFFFF_FFFF}};
      feed(50);
      in_valid = 1'b0;
      check("max_valid", out_valid, 1);
      check("max_result", result, {CH{38'h31_FFFF_FFCE}});
      step();
      check("max_idle", busy, 0);

      // continuous mode with back-pressure
      out_ready = 1'b0;
      open_window(1'b1);
      in_valid = 1'b1;
      in_data  = dat4(5, 6, 7, 8);
      feed(50);
      check("ct_valid", out_valid, 1);
      check("ct_result1", result, res4(250, 300, 350, 400));
      check("ct_in_ready_low", in_ready, 0);
      feed(3);
      check("ct_stall_count", count, 0);
      check("ct_stall_valid", out_valid, 1);
      check("ct_stall_result", result, res4(250, 300, 350, 400));
      check("ct_stall_busy", busy, 1);
      out_ready = 1'b1;
      #1;
      check("ct_in_ready_high", in_ready, 1);
      step();
      out_ready = 1'b0;
      check("ct_xfer_valid", out_valid, 0);
      check("ct_xfer_count", count, 1);
      feed(49);
      check("ct_valid2", out_valid, 1);
      check("ct_result2", result, res4(250, 300, 350, 400));
      check("ct_still_acc", busy, 1);
      fin = 1'b1;
      step();
      fin = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("ct_fin_busy", busy, 0);
      check("ct_fin_valid", out_valid, 0);

      // abort at count 25 with start and in_valid also high
      open_window(1'b0);
      in_valid = 1'b1;
      in_data  = dat4(1, 1, 1, 1);
      feed(25);
      check("ab_count25", count, 25);
      fin = 1'b1; start = 1'b1;
      step();
      fin = 1'b0; start = 1'b0; in_valid = 1'b0;
      check("ab_busy", busy, 0);
      check("ab_count", count, 0);
      check("ab_valid", out_valid, 0);
      feed(3);
      check("ab_no_result", out_valid, 0);
      check("ab_idle", busy, 0);

      // random in_valid, random data
      for (int k = 0; k < CH; k++) sums[k] = '0;
      acc_n = 0;
      cyc   = 0;
      open_window(1'b0);
      while (acc_n < CGES && cyc < 2000) begin
         in_valid = 1'($urandom_range(0, 1));
         for (int k = 0; k < CH; k++) begin
            smp = $urandom;
            in_data[k*BITS +: BITS] = smp;
            if (in_valid) sums[k] = sums[k] + ACCW'(smp);
         end
         if (in_valid) acc_n++;
         step();
         cyc++;
         if (acc_n < CGES) check("rnd_count", count, (CH*ACCW)'(acc_n));
      end
      in_valid = 1'b0;
      check("rnd_accepts", acc_n, CGES);
      check("rnd_valid", out_valid, 1);
      check("rnd_result", result, res4(sums[0], sums[1], sums[2], sums[3]));
      step();
      check("rnd_idle", busy, 0);

      // reset mid-window
      open_window(1'b0);
      in_valid = 1'b1;
      in_data  = dat4(3, 3, 3, 3);
      feed(30);
      check("mr_count30", count, 30);
      #2 reset_n = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_count", count, 0);
      check("mr_valid", out_valid, 0);
      check("mr_in_ready", in_ready, 0);
      check("mr_result", result, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b1;
      step();
      open_window(1'b0);
      in_valid = 1'b1;
      in_data  = dat4(9, 10, 11, 12);
      feed(50);
      in_valid = 1'b0;
      check("mr_valid_after", out_valid, 1);
      check("mr_result_after", result, res4(450, 500, 550, 600));
      step();
      check("mr_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
